// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and state type for the instruction-fetch
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          XLEN_DEF  = 64;
    localparam int          ILEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          PC_STEP   = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Holds the PC, drives the instruction
//               memory address, registers the returned instruction with its
//               PC into the IF/ID register and hands it to decode over a
//               valid/ready handshake. Handles redirects from execute, traps
//               misaligned redirect targets and counts accepted fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [ILEN-1:0]    imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [ILEN-1:0]    if_instr,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(PC_STEP);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic            load;
    logic            fire_out;

    // Decode has taken the current output register this cycle.
    assign fire_out    = if_valid && id_ready;
    assign imem_addr   = pc;
    assign fetch_fault = (state == FAULT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load decision; a redirect overrides everything else and
    // its target alignment alone decides between RUN and FAULT.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     load = !if_valid || id_ready;
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase
        if (redirect_valid) begin
            load       = 1'b0;
            state_next = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
        end
    end

    // PC, IF/ID output register and accepted-fetch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_instr    <= NOP_INSTR;
            fetch_count <= 32'd0;
        end else begin
            // The handshake completes even when a redirect flushes the slot.
            if (fire_out) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
                pc       <= redirect_pc;
            end else if (load) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_instr;
                pc       <= pc + PC_INC;
            end
        end
    end

endmodule
`default_nettype wire
